// File: rtl/fib_nth_server.sv
// fib_nth_server: shared Fibonacci engine behind a two-requester round-robin front end.
// Computes F(n) with F(0)=F(1)=1, modulo 2^W, with a sticky overflow flag.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   req_valid[1:0]  per-requester request valid
//   req_n[2*NW-1:0] per-requester index, requester i in bits [i*NW +: NW]
//   req_ready[1:0]  combinational grant, one-hot or zero, only in IDLE
//   rsp_valid/rsp_ready  response handshake
//   rsp_data, rsp_id, rsp_ovf  result, issuing requester, true-value overflow
//   busy            registered, high whenever the FSM is not IDLE
module fib_nth_server #(
    parameter int unsigned W           = 16,
    parameter int unsigned NW          = 8,
    parameter int unsigned DOUBLE_RATE = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    input  logic [2*NW-1:0] req_n,
    output logic [1:0]      req_ready,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [W-1:0]    rsp_data,
    output logic            rsp_id,
    output logic            rsp_ovf,
    output logic            busy
);

    localparam int unsigned SW = W + 2;

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    state_t          state, state_d;
    logic [W-1:0]    a, b, a_d, b_d;
    logic            a_ovf, b_ovf, a_ovf_d, b_ovf_d;
    logic [NW-1:0]   cnt, cnt_d, sel_n;
    logic            id, id_d, last_grant, last_grant_d;
    logic            rsp_valid_d, rsp_id_d, rsp_ovf_d, busy_d;
    logic [W-1:0]    rsp_data_d;
    logic [SW-1:0]   sum_ab, sum_abb;
    logic            ovf_ab, ovf_abb;

    // Widened sums so the carry-out beyond W bits is visible to the overflow flags
    assign sum_ab  = SW'(a) + SW'(b);
    assign sum_abb = sum_ab + SW'(b);
    assign ovf_ab  = (sum_ab[SW-1:W] != 2'b00) | a_ovf | b_ovf;
    assign ovf_abb = (sum_abb[SW-1:W] != 2'b00) | a_ovf | b_ovf;

    // Round-robin grant: a tie goes to the requester not granted last
    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE && !rst) begin
            if (req_valid[0] && (!req_valid[1] || last_grant))
                req_ready = 2'b01;
            else if (req_valid[1])
                req_ready = 2'b10;
        end
    end

    assign sel_n = req_ready[1] ? req_n[2*NW-1:NW] : req_n[NW-1:0];

    // Next-state and datapath update
    always_comb begin
        state_d      = state;
        a_d          = a;
        b_d          = b;
        a_ovf_d      = a_ovf;
        b_ovf_d      = b_ovf;
        cnt_d        = cnt;
        id_d         = id;
        last_grant_d = last_grant;
        rsp_valid_d  = rsp_valid;
        rsp_data_d   = rsp_data;
        rsp_id_d     = rsp_id;
        rsp_ovf_d    = rsp_ovf;
        case (state)
            IDLE: begin
                if (req_ready != 2'b00) begin
                    a_d          = W'(1);
                    b_d          = W'(1);
                    a_ovf_d      = 1'b0;
                    b_ovf_d      = 1'b0;
                    cnt_d        = sel_n;
                    id_d         = req_ready[1];
                    last_grant_d = req_ready[1];
                    state_d      = RUN;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = a;
                    rsp_ovf_d   = a_ovf;
                    rsp_id_d    = id;
                    state_d     = RESP;
                end else if (DOUBLE_RATE != 0 && cnt >= NW'(2)) begin
                    a_d     = sum_ab[W-1:0];
                    a_ovf_d = ovf_ab;
                    b_d     = sum_abb[W-1:0];
                    b_ovf_d = ovf_abb;
                    cnt_d   = cnt - NW'(2);
                end else begin
                    a_d     = b;
                    a_ovf_d = b_ovf;
                    b_d     = sum_ab[W-1:0];
                    b_ovf_d = ovf_ab;
                    cnt_d   = cnt - NW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a          <= '0;
            b          <= '0;
            a_ovf      <= 1'b0;
            b_ovf      <= 1'b0;
            cnt        <= '0;
            id         <= 1'b0;
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
            rsp_ovf    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            a          <= a_d;
            b          <= b_d;
            a_ovf      <= a_ovf_d;
            b_ovf      <= b_ovf_d;
            cnt        <= cnt_d;
            id         <= id_d;
            last_grant <= last_grant_d;
            rsp_valid  <= rsp_valid_d;
            rsp_data   <= rsp_data_d;
            rsp_id     <= rsp_id_d;
            rsp_ovf    <= rsp_ovf_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_fib_nth_server.sv
// Bench for fib_nth_server: single- and double-rate instances share the request side.
module tb_fib_nth_server;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_n;
    logic        rsp_ready;

    logic [1:0]  rr_s, rr_d;
    logic        rv_s, rv_d, ri_s, ri_d, ro_s, ro_d, bs_s, bs_d;
    logic [15:0] rd_s, rd_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fib_nth_server #(.W(16), .NW(8), .DOUBLE_RATE(0)) dut_s (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_n(req_n),
        .req_ready(rr_s), .rsp_valid(rv_s), .rsp_ready(rsp_ready),
        .rsp_data(rd_s), .rsp_id(ri_s), .rsp_ovf(ro_s), .busy(bs_s));

    fib_nth_server #(.W(16), .NW(8), .DOUBLE_RATE(1)) dut_d (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_n(req_n),
        .req_ready(rr_d), .rsp_valid(rv_d), .rsp_ready(rsp_ready),
        .rsp_data(rd_d), .rsp_id(ri_d), .rsp_ovf(ro_d), .busy(bs_d));

    typedef struct {
        logic        id;
        logic [7:0]  n;
        logic [15:0] data;
        logic        ovf;
        int          lat_s;
        int          lat_d;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one request to both instances and check result, id, ovf and latency
    task automatic run_vec(input vec_t v);
        int ls, ld;
        logic [15:0] ds, dd;
        logic is_, id_, os, od;
        ls = 0; ld = 0; ds = '0; dd = '0; is_ = 0; id_ = 0; os = 0; od = 0;
        @(negedge clk);
        req_n = '0;
        if (v.id) req_n[15:8] = v.n; else req_n[7:0] = v.n;
        req_valid = v.id ? 2'b10 : 2'b01;
        #1;
        chk("grant_s", 32'(rr_s), 32'(req_valid));
        chk("grant_d", 32'(rr_d), 32'(req_valid));
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        chk("busy_rise_s", 32'(bs_s), 32'd1);
        chk("busy_rise_d", 32'(bs_d), 32'd1);
        for (int k = 1; k <= 300 && (ls == 0 || ld == 0); k++) begin
            if (k > 1) @(negedge clk);
            if (ls == 0 && rv_s) begin ls = k; ds = rd_s; is_ = ri_s; os = ro_s; end
            if (ld == 0 && rv_d) begin ld = k; dd = rd_d; id_ = ri_d; od = ro_d; end
        end
        chk("lat_s", 32'(ls), 32'(v.lat_s));
        chk("lat_d", 32'(ld), 32'(v.lat_d));
        chk("data_s", 32'(ds), 32'(v.data));
        chk("data_d", 32'(dd), 32'(v.data));
        chk("id_s", 32'(is_), 32'(v.id));
        chk("id_d", 32'(id_), 32'(v.id));
        chk("ovf_s", 32'(os), 32'(v.ovf));
        chk("ovf_d", 32'(od), 32'(v.ovf));
        repeat (2) @(negedge clk);
        chk("idle_s", 32'({bs_s, rv_s}), 32'd0);
        chk("idle_d", 32'({bs_d, rv_d}), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[7];
        logic [15:0] tie_data[4];
        logic        tie_id[4];
        int ns, nd, gs, gd;
        logic both_s, both_d;

        vecs[0] = '{id: 1'b0, n: 8'd0,  data: 16'd1,     ovf: 1'b0, lat_s: 2,  lat_d: 2};
        vecs[1] = '{id: 1'b1, n: 8'd10, data: 16'd89,    ovf: 1'b0, lat_s: 12, lat_d: 7};
        vecs[2] = '{id: 1'b0, n: 8'd23, data: 16'd46368, ovf: 1'b0, lat_s: 25, lat_d: 14};
        vecs[3] = '{id: 1'b1, n: 8'd24, data: 16'd9489,  ovf: 1'b1, lat_s: 26, lat_d: 14};
        vecs[4] = '{id: 1'b0, n: 8'd1,  data: 16'd1,     ovf: 1'b0, lat_s: 3,  lat_d: 3};
        vecs[5] = '{id: 1'b1, n: 8'd2,  data: 16'd2,     ovf: 1'b0, lat_s: 4,  lat_d: 3};
        vecs[6] = '{id: 1'b0, n: 8'd5,  data: 16'd8,     ovf: 1'b0, lat_s: 7,  lat_d: 5};
        tie_data = '{16'd3, 16'd5, 16'd3, 16'd5};
        tie_id   = '{1'b0, 1'b1, 1'b0, 1'b1};

        // Reset with a tie already pending
        rst = 1'b1;
        req_valid = 2'b11;
        req_n = {8'd4, 8'd3};
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_s", 32'({rv_s, rd_s, ri_s, ro_s, bs_s}), 32'd0);
        chk("reset_out_d", 32'({rv_d, rd_d, ri_d, ro_d, bs_d}), 32'd0);
        chk("reset_ready_s", 32'(rr_s), 32'd0);
        chk("reset_ready_d", 32'(rr_d), 32'd0);
        rst = 1'b0;

        // Repeated ties: grants alternate 0,1,0,1
        ns = 0; nd = 0; gs = 0; gd = 0; both_s = 0; both_d = 0;
        for (int c = 0; c < 200 && (ns < 4 || nd < 4); c++) begin
            #1;
            if (rr_s == 2'b11) both_s = 1;
            if (rr_d == 2'b11) both_d = 1;
            if (rr_s != 2'b00 && gs < 4) begin
                chk("tie_grant_s", 32'(rr_s), gs[0] ? 32'd2 : 32'd1); gs++;
            end
            if (rr_d != 2'b00 && gd < 4) begin
                chk("tie_grant_d", 32'(rr_d), gd[0] ? 32'd2 : 32'd1); gd++;
            end
            if (rv_s && ns < 4) begin
                chk("tie_data_s", 32'(rd_s), 32'(tie_data[ns]));
                chk("tie_id_s", 32'(ri_s), 32'(tie_id[ns])); ns++;
            end
            if (rv_d && nd < 4) begin
                chk("tie_data_d", 32'(rd_d), 32'(tie_data[nd]));
                chk("tie_id_d", 32'(ri_d), 32'(tie_id[nd])); nd++;
            end
            @(negedge clk);
        end
        chk("tie_count_s", 32'(ns), 32'd4);
        chk("tie_count_d", 32'(nd), 32'd4);
        chk("tie_onehot_s", 32'(both_s), 32'd0);
        chk("tie_onehot_d", 32'(both_d), 32'd0);
        req_valid = 2'b00;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Backpressure: response held, pending request not accepted
        @(negedge clk);
        rsp_ready = 1'b0;
        req_n = {8'd2, 8'd5};
        req_valid = 2'b01;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b10;
        for (int k = 0; k < 50 && !(rv_s && rv_d); k++) @(negedge clk);
        chk("bp_wait", 32'({rv_s, rv_d}), 32'd3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_s", 32'({rv_s, rd_s, ri_s, ro_s}), {15'd0, 1'b1, 16'd8, 2'b00} >> 0);
            chk("bp_hold_d", 32'({rv_d, rd_d, ri_d, ro_d}), {15'd0, 1'b1, 16'd8, 2'b00} >> 0);
            chk("bp_noacc_s", 32'({rr_s, bs_s}), 32'd1);
            chk("bp_noacc_d", 32'({rr_d, bs_d}), 32'd1);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_hs_noacc_s", 32'(rr_s), 32'd0);
        chk("bp_hs_noacc_d", 32'(rr_d), 32'd0);
        @(negedge clk);
        chk("bp_after_s", 32'({rv_s, bs_s, rr_s}), 32'd2);
        chk("bp_after_d", 32'({rv_d, bs_d, rr_d}), 32'd2);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (8) @(negedge clk);
        chk("bp_done_s", 32'({rv_s, bs_s, rd_s, ri_s}), {13'd0, 2'b00, 16'd2, 1'b1});
        chk("bp_done_d", 32'({rv_d, bs_d, rd_d, ri_d}), {13'd0, 2'b00, 16'd2, 1'b1});

        // Reset mid-RUN, then re-present the request
        @(negedge clk);
        req_n = {8'd0, 8'd20};
        req_valid = 2'b01;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_s", 32'({rv_s, rd_s, ri_s, ro_s, bs_s}), 32'd0);
        chk("midrst_out_d", 32'({rv_d, rd_d, ri_d, ro_d, bs_d}), 32'd0);
        chk("midrst_ready_s", 32'(rr_s), 32'd0);
        rst = 1'b0;
        run_vec('{id: 1'b0, n: 8'd20, data: 16'd10946, ovf: 1'b0, lat_s: 22, lat_d: 12});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fib_nth_server.md
# fib_nth_server

Shared Fibonacci engine with a two-port request front end. Each requester asks for F(n), indexed from F(0)=1, F(1)=1, F(k)=F(k-1)+F(k-2) mod 2^W. The block arbitrates round-robin between the two requesters and sequences an internal two-register Fibonacci stepper. The stepper runs single rate (one step per cycle) or double rate (two steps per cycle). The result is returned on a valid/ready response channel tagged with the requester id. It sits between sequential-basics producers and any consumer needing indexed Fibonacci values.

## Interface
- W, 16, result width
- NW, 8, index width
- DOUBLE_RATE, 0, 0: one step per cycle; 1: two steps per cycle
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  bit i: requester i has a pending request
- req_n  in   2*NW  request index; bits [i*NW +: NW] belong to requester i
- req_ready  out  2  bit i: requester i's request accepted this cycle; at most one bit set
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  W  F(n) mod 2^W
- rsp_id  out  1  requester that issued this result
- rsp_ovf  out  1  true F(n) ≥ 2^W
- busy  out  1  high in any state other than IDLE

## Operation
- One clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- FSM states: IDLE, RUN, RESP. Reset enters IDLE.
- IDLE:
  - req_ready is combinational and asserted only in IDLE, only to the winner, only while rst=0.
  - Winner rules: only one req_valid bit set → that requester. Both set → the requester not granted last. last_grant resets to 1, so requester 0 wins the first tie.
  - On accept (req_valid[i] & req_ready[i]): a←1, b←1, ovf flags cleared, cnt←req_n[i], id←i, last_grant←i; go to RUN.
- RUN, single rate:
  - cnt≠0: {a,b}←{b, a+b}; cnt←cnt−1.
  - cnt=0: rsp_data←a, rsp_ovf←a_ovf, rsp_id←id; go to RESP.
- RUN, double rate:
  - cnt≥2: {a,b}←{a+b, a+2b}; cnt←cnt−2.
  - cnt=1: single step.
  - cnt=0: capture as above.
- Overflow tracking:
  - a and b each carry a sticky overflow flag.
  - Flag of a sum = carry-out beyond W bits, OR the flag of any operand.
  - A register that receives a copy (single-rate a←b) inherits the source's flag.
  - Internal sums are computed at W+2 bits; the stored value is truncated to W bits.
- RESP:
  - rsp_valid=1; rsp_data, rsp_id and rsp_ovf are held stable until rsp_valid & rsp_ready.
  - On that handshake: go to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- Requester protocol: req_valid and req_n must be held stable until accepted. The block never drops an accepted request except on rst.
- rst in any state: return to IDLE and discard any in-flight computation. The requester must re-present the request.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_ovf=0, busy=0, state=IDLE, last_grant=1.
- Accept in cycle T.
  - Single rate: rsp_valid first high in cycle T+2+n.
  - Double rate: rsp_valid first high in cycle T+2+ceil(n/2).
- busy is registered. It rises in the cycle after accept and falls in the cycle after the response handshake.
- Minimum spacing between accepts, with rsp_ready held high:
  - single rate: n+3 cycles;
  - double rate: ceil(n/2)+3 cycles.
- n=0 produces 1 with latency 2 in both modes.
- Maximum index is 2^NW−1. Results wrap mod 2^W, and rsp_ovf is set once the true value overflows.

## Test plan
- Single rate, req0 with n=0: accepted at T; rsp_valid at T+2 with rsp_data=1, rsp_id=0, rsp_ovf=0.
- Single rate, req1 with n=10: rsp_data=89, rsp_id=1, rsp_valid at T+12. Double rate, same request: rsp_data=89 at T+7.
- Overflow boundary, run in both modes:
  - n=23 → rsp_data=46368, rsp_ovf=0;
  - n=24 → rsp_data=9489 (75025 mod 65536), rsp_ovf=1.
- Tie arbitration: both req_valid high from reset, n0=3, n1=4.
  - Grants go to 0 then 1, and alternate on repeated ties.
  - Results: 3 (id 0), then 5 (id 1).
  - req_ready is never set for both requesters in one cycle.
- Backpressure: rsp_ready held low 5 cycles after rsp_valid.
  - rsp_data, rsp_id and rsp_ovf stay stable; no new accept occurs.
  - After the handshake, the next accept happens no earlier than the following cycle.
- Reset mid-RUN: n=20 accepted, rst pulsed 1 cycle at T+5.
  - All outputs return to their reset values in the next cycle.
  - The re-presented request completes with rsp_data=10946.
